// File: rtl/sos_pkg.sv
// Shared definitions for the biquad-cascade sequencer: datapath widths and
// controller state encoding.
package sos_pkg;
  localparam int DATA_W = 16;
  localparam int SEC_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_e;
endpackage

// File: rtl/sos_cascade_ctrl.sv
// Time-multiplexes one shared biquad datapath over up to NSEC sections,
// feeding each section's result back in as the next section's input.
module sos_cascade_ctrl
  import sos_pkg::*;
#(
  parameter int NSEC    = 4,
  parameter int SOS_LAT = 2
) (
  input  logic              CLK,
  input  logic              nReset,
  input  logic [DATA_W-1:0] din,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEC_W-1:0]  nsec_cfg,
  output logic [DATA_W-1:0] dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sos_din,
  output logic              sos_CE,
  output logic [SEC_W-1:0]  sos_sec,
  input  logic [DATA_W-1:0] sos_dout,
  output logic              busy
);

  localparam logic [SEC_W-1:0] NSEC_C   = SEC_W'(NSEC);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(SOS_LAT - 1);

  state_e            state_q, state_d;
  logic [SEC_W-1:0]  k_q, k_d;
  logic [SEC_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] sos_din_q, sos_din_d;
  logic [SEC_W-1:0]  sos_sec_q, sos_sec_d;
  logic              in_ready_q, in_ready_d;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dout_d    = dout_q;
    sos_din_d = sos_din_q;
    sos_sec_d = sos_sec_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d = din;
          n_d    = (nsec_cfg > NSEC_C) ? NSEC_C : nsec_cfg;
          k_d    = '0;
          cnt_d  = '0;
          if (n_d == '0) begin
            state_d = OUTPUT;
            dout_d  = din;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          // Section result becomes the next section's input.
          work_d = sos_dout;
          cnt_d  = '0;
          k_d    = k_q + SEC_W'(1);
          if (k_d < n_q) begin
            state_d = ISSUE;
          end else begin
            state_d = OUTPUT;
            dout_d  = sos_dout;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUTPUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Datapath operands are registered on entry to ISSUE and held otherwise.
    if (state_d == ISSUE) begin
      sos_din_d = work_d;
      sos_sec_d = k_d;
    end

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      work_q     <= '0;
      dout_q     <= '0;
      sos_din_q  <= '0;
      sos_sec_q  <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dout_q     <= dout_d;
      sos_din_q  <= sos_din_d;
      sos_sec_q  <= sos_sec_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == OUTPUT);
  assign sos_CE    = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;
  assign sos_din   = sos_din_q;
  assign sos_sec   = sos_sec_q;

endmodule

// File: tb/tb_sos_cascade_ctrl.sv
// Randomized self-checking bench for sos_cascade_ctrl with a stub datapath
// returning sos_din + 1 + sos_sec after SOS_LAT cycles.
module tb_sos_cascade_ctrl;
  localparam int NSEC    = 4;
  localparam int SOS_LAT = 2;

  logic        CLK = 1'b0;
  logic        nReset;
  logic [15:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  nsec_cfg;
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sos_din;
  logic        sos_CE;
  logic [2:0]  sos_sec;
  logic [15:0] sos_dout;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  sos_cascade_ctrl #(.NSEC(NSEC), .SOS_LAT(SOS_LAT)) dut (
    .CLK(CLK), .nReset(nReset), .din(din), .in_valid(in_valid),
    .in_ready(in_ready), .nsec_cfg(nsec_cfg), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .sos_din(sos_din),
    .sos_CE(sos_CE), .sos_sec(sos_sec), .sos_dout(sos_dout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  logic [15:0] stub_q [SOS_LAT];
  always @(posedge CLK) begin
    stub_q[0] <= sos_din + 16'd1 + {13'd0, sos_sec};
    for (int i = 1; i < SOS_LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign sos_dout = stub_q[SOS_LAT-1];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got hang, need finish)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Section k adds 1+k in the stub, so n sections add sum of (1+k).
  function automatic logic [15:0] model(input logic [15:0] d, input int n);
    logic [15:0] r;
    r = d;
    for (int j = 0; j < n; j++) r = r + 16'(1 + j);
    return r;
  endfunction

  function automatic int eff_n(input logic [2:0] cfg);
    return (int'(cfg) > NSEC) ? NSEC : int'(cfg);
  endfunction

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_sos_CE"}, sos_CE, 0);
    chk({pfx, "_sos_din"}, sos_din, 0);
    chk({pfx, "_sos_sec"}, sos_sec, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  // One sample: accept, watch section strobes, check latency/result/handshake.
  task automatic run_sample(input logic [15:0] d, input logic [2:0] cfg, input int stall);
    int n, lat, ce, w;
    logic [15:0] exp, run;
    n   = eff_n(cfg);
    exp = model(d, n);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge CLK); w++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    din       = d;
    nsec_cfg  = cfg;
    out_ready = (stall == 0);
    @(negedge CLK);
    in_valid = 1'b0;
    din      = 16'($urandom);
    nsec_cfg = 3'($urandom);
    lat = 1; ce = 0; run = d;
    while (!out_valid && lat < 200) begin
      if (sos_CE) begin
        chk("sec_order", sos_sec, ce);
        chk("sec_din", sos_din, run);
        run = run + 16'(1 + ce);
        ce++;
      end
      if (in_ready) chk("in_ready_busy", in_ready, 0);
      @(negedge CLK);
      lat++;
      nsec_cfg = 3'($urandom);
      in_valid = 1'($urandom);
      din      = 16'($urandom);
    end
    in_valid = 1'b0;
    chk("latency", lat, n * (1 + SOS_LAT) + 1);
    chk("ce_count", ce, n);
    chk("dout", dout, exp);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_dout", dout, exp);
      chk("stall_in_ready", in_ready, 0);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] q[$];
    int cyc, acc_prev, acc_n, w;
    nReset = 1'b0; din = '0; in_valid = 1'b0; nsec_cfg = '0; out_ready = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk_reset_outputs("rst");
    nReset = 1'b1;
    @(negedge CLK);
    chk("rst_release_in_ready", in_ready, 1);

    run_sample(16'h0010, 3'd4, 0);
    chk("dir_0010", dout, 16'h001A);
    run_sample(16'h1234, 3'd0, 0);
    run_sample(16'h0100, 3'd7, 0);
    run_sample(16'hFFFE, 3'd4, 5);
    run_sample(16'h7FFF, 3'd1, 2);

    // Reset during the second section's WAIT.
    in_valid = 1'b1; din = 16'h0abc; nsec_cfg = 3'd4; out_ready = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    acc_n = 0; w = 0;
    while (acc_n < 2 && w < 50) begin
      if (sos_CE) acc_n++;
      @(negedge CLK); w++;
    end
    chk("rst_mid_reached", acc_n, 2);
    nReset = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("rst_mid");
    nReset = 1'b1;
    @(negedge CLK);
    chk("rst_mid_in_ready", in_ready, 1);
    for (int i = 0; i < 15; i++) begin
      if (out_valid) chk("rst_mid_no_valid", out_valid, 0);
      @(negedge CLK);
    end
    run_sample(16'h0abc, 3'd4, 1);

    for (int i = 0; i < 10; i++)
      run_sample(16'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; out_ready = 1'b1; nsec_cfg = 3'd4; din = 16'($urandom);
    cyc = 0; acc_prev = -1; acc_n = 0;
    while ((acc_n < 4 || q.size() != 0) && cyc < 200) begin
      if (out_valid) begin
        chk("b2b_have_exp", (q.size() != 0), 1);
        if (q.size() != 0) chk("b2b_dout", dout, q.pop_front());
      end
      if (in_ready && in_valid) begin
        if (acc_prev >= 0) chk("b2b_period", cyc - acc_prev, 14);
        acc_prev = cyc;
        acc_n++;
        q.push_back(model(din, 4));
        @(negedge CLK); cyc++;
        din = 16'($urandom);
        if (acc_n == 4) in_valid = 1'b0;
      end else begin
        @(negedge CLK); cyc++;
      end
    end
    chk("b2b_drained", q.size(), 0);
    chk("b2b_accepts", acc_n, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
